// File: rtl/regwr_arbiter_pkg.sv
// Shared widths, constants and the write-entry payload for the register-file write-port arbiter.
package regwr_arbiter_pkg;

    localparam int unsigned RegAddrW       = 5;
    localparam int unsigned RegW           = 32;
    localparam int unsigned RegNum         = 32;
    localparam int unsigned RegWrFifoDepth = 2;
    localparam int unsigned EntryW         = RegAddrW + RegW;

    localparam logic [RegW-1:0]     ZeroWord    = '0;
    localparam logic [RegAddrW-1:0] ZeroAddr    = '0;
    localparam logic                WriteEnable = 1'b1;
    localparam logic                ReadEnable  = 1'b1;

    typedef struct packed {
        logic [RegAddrW-1:0] waddr;
        logic [RegW-1:0]     wdata;
    } regwr_entry_t;

endpackage

// File: rtl/regwr_fifo.sv
// Small power-of-two FIFO; push when full and pop when empty are ignored.
module regwr_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CntW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; an entry is only read once count says it is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/regwr_arbiter.sv
// Register-file write-port arbiter (writeback first, then queued long-latency results)
// plus a pending-write scoreboard that stalls decode on RAW/WAW against in-flight ops.
module regwr_arbiter
    import regwr_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = RegWrFifoDepth,
    parameter int unsigned NREG  = RegNum
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_we,
    input  logic [RegAddrW-1:0] wb_waddr,
    input  logic [RegW-1:0]     wb_wdata,
    input  logic                lu_valid,
    output logic                lu_ready,
    input  logic [RegAddrW-1:0] lu_waddr,
    input  logic [RegW-1:0]     lu_wdata,
    input  logic                iss_valid,
    input  logic [RegAddrW-1:0] iss_waddr,
    input  logic                rd_re1,
    input  logic                rd_re2,
    input  logic [RegAddrW-1:0] rd_raddr1,
    input  logic [RegAddrW-1:0] rd_raddr2,
    output logic                stall_req,
    output logic                rf_we,
    output logic [RegAddrW-1:0] rf_waddr,
    output logic [RegW-1:0]     rf_wdata,
    output logic [NREG-1:0]     pending
);

    regwr_entry_t    fifo_din;
    regwr_entry_t    fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            wb_sel;
    logic            popping;
    logic            hit1;
    logic            hit2;
    logic            hit_iss;
    logic [NREG-1:0] pending_d;

    assign lu_ready  = !fifo_full;
    // Results for r0 are handshaken but dropped.
    assign fifo_push = lu_valid && lu_ready && (lu_waddr != ZeroAddr);
    assign fifo_din  = '{waddr: lu_waddr, wdata: lu_wdata};
    assign wb_sel    = (wb_we == WriteEnable) && (wb_waddr != ZeroAddr);
    assign popping   = !wb_sel && !fifo_empty;

    regwr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (popping),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Write-port select.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = ZeroAddr;
        rf_wdata = ZeroWord;
        if (wb_sel) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
        end else if (popping) begin
            rf_we    = 1'b1;
            rf_waddr = fifo_head.waddr;
            rf_wdata = fifo_head.wdata;
        end
    end

    // A register popped this cycle is forwarded by the file, so it no longer blocks.
    always_comb begin
        hit1      = pending[rd_raddr1] && !(popping && rf_waddr == rd_raddr1);
        hit2      = pending[rd_raddr2] && !(popping && rf_waddr == rd_raddr2);
        hit_iss   = pending[iss_waddr] && !(popping && rf_waddr == iss_waddr);
        stall_req = ((rd_re1 == ReadEnable) && (rd_raddr1 != ZeroAddr) && hit1)
                 || ((rd_re2 == ReadEnable) && (rd_raddr2 != ZeroAddr) && hit2)
                 || (iss_valid && (iss_waddr != ZeroAddr) && hit_iss);
    end

    // Clear applied before set so a same-edge set (newer op) wins.
    always_comb begin
        pending_d = pending;
        if (popping) pending_d[fifo_head.waddr] = 1'b0;
        if (iss_valid && !stall_req && (iss_waddr != ZeroAddr)) pending_d[iss_waddr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending <= '0;
        else      pending <= pending_d;
    end

endmodule

// File: tb/tb_regwr_arbiter.sv
// Directed self-checking bench for regwr_arbiter.
module tb_regwr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic        rd_re1;
    logic        rd_re2;
    logic [4:0]  rd_raddr1;
    logic [4:0]  rd_raddr2;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regwr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_waddr  (lu_waddr),
        .lu_wdata  (lu_wdata),
        .iss_valid (iss_valid),
        .iss_waddr (iss_waddr),
        .rd_re1    (rd_re1),
        .rd_re2    (rd_re2),
        .rd_raddr1 (rd_raddr1),
        .rd_raddr2 (rd_raddr2),
        .stall_req (stall_req),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pending   (pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let combinational outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        lu_valid = 1; lu_waddr = 5'd4; lu_wdata = 32'h1234;
        iss_valid = 1; iss_waddr = 5'd5;
        rd_re1 = 0; rd_re2 = 0; rd_raddr1 = 0; rd_raddr2 = 0;

        // Reset with valids high: nothing may be captured.
        #2;
        chk("rst_lu_ready", 32'(lu_ready), 32'd1);
        chk("rst_rf_we",    32'(rf_we),    32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata,      32'd0);
        chk("rst_pending",  pending,       32'd0);
        chk("rst_stall",    32'(stall_req), 32'd0);
        tick();
        chk("rst_hold_pending", pending, 32'd0);
        chk("rst_hold_rf_we", 32'(rf_we), 32'd0);
        lu_valid = 0; iss_valid = 0;
        rst = 1'b1;

        // Issue r5.
        iss_valid = 1; iss_waddr = 5'd5;
        settle();
        chk("iss5_stall", 32'(stall_req), 32'd0);
        tick();
        chk("iss5_pending", pending, 32'h0000_0020);
        iss_valid = 0;

        // Long-latency result for r5, writeback idle.
        lu_valid = 1; lu_waddr = 5'd5; lu_wdata = 32'hDEAD_BEEF;
        settle();
        chk("lu5_ready", 32'(lu_ready), 32'd1);
        chk("lu5_pre_rf_we", 32'(rf_we), 32'd0);
        tick();
        lu_valid = 0;
        settle();
        chk("lu5_rf_we",    32'(rf_we),    32'd1);
        chk("lu5_rf_waddr", 32'(rf_waddr), 32'd5);
        chk("lu5_rf_wdata", rf_wdata,      32'hDEAD_BEEF);
        chk("lu5_pend_hold", pending,      32'h0000_0020);
        tick();
        chk("lu5_pend_clr", pending,       32'd0);
        chk("lu5_post_rf_we", 32'(rf_we),  32'd0);

        // Writeback hogs the port while two results queue up.
        wb_we = 1; wb_waddr = 5'd3; wb_wdata = 32'h1111_1111;
        lu_valid = 1; lu_waddr = 5'd10; lu_wdata = 32'hAAAA_0001;
        tick();
        lu_waddr = 5'd11; lu_wdata = 32'hBBBB_0002;
        tick();
        lu_waddr = 5'd12; lu_wdata = 32'hCCCC_0003;
        settle();
        chk("full_ready", 32'(lu_ready), 32'd0);
        chk("full_rf_waddr", 32'(rf_waddr), 32'd3);
        chk("full_rf_wdata", rf_wdata, 32'h1111_1111);
        tick();
        chk("full_held_ready", 32'(lu_ready), 32'd0);
        chk("full_held_rf_waddr", 32'(rf_waddr), 32'd3);
        wb_we = 0;
        settle();
        chk("drain0_ready_low", 32'(lu_ready), 32'd0);
        chk("drain0_waddr", 32'(rf_waddr), 32'd10);
        chk("drain0_wdata", rf_wdata, 32'hAAAA_0001);
        tick();
        chk("drain1_ready", 32'(lu_ready), 32'd1);
        chk("drain1_waddr", 32'(rf_waddr), 32'd11);
        chk("drain1_wdata", rf_wdata, 32'hBBBB_0002);
        tick();
        lu_valid = 0;
        settle();
        chk("drain2_waddr", 32'(rf_waddr), 32'd12);
        chk("drain2_wdata", rf_wdata, 32'hCCCC_0003);
        tick();
        chk("drain_done_we", 32'(rf_we), 32'd0);
        chk("drain_pending", pending, 32'd0);

        // RAW on r7; r0 and r8 never stall.
        iss_valid = 1; iss_waddr = 5'd7;
        tick();
        iss_valid = 0;
        chk("raw_pending", pending, 32'h0000_0080);
        rd_re1 = 1; rd_raddr1 = 5'd7;
        settle();
        chk("raw_stall", 32'(stall_req), 32'd1);
        rd_re1 = 0; rd_re2 = 1; rd_raddr2 = 5'd8;
        settle();
        chk("raw_r8_nostall", 32'(stall_req), 32'd0);
        rd_raddr2 = 5'd0;
        settle();
        chk("raw_r0_nostall", 32'(stall_req), 32'd0);
        rd_re2 = 0; rd_re1 = 1; rd_raddr1 = 5'd7;
        lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 32'h0000_0077;
        settle();
        chk("raw_stall_enq", 32'(stall_req), 32'd1);
        tick();
        lu_valid = 0;
        wb_we = 1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF_FFFF;
        settle();
        chk("raw_pop_stall", 32'(stall_req), 32'd0);
        chk("raw_pop_waddr", 32'(rf_waddr), 32'd7);
        chk("raw_pop_wdata", rf_wdata, 32'h0000_0077);
        tick();
        wb_we = 0; rd_re1 = 0;
        chk("raw_pending_clr", pending, 32'd0);

        // WAW on r9.
        iss_valid = 1; iss_waddr = 5'd9;
        tick();
        chk("waw_pending", pending, 32'h0000_0200);
        settle();
        chk("waw_stall", 32'(stall_req), 32'd1);
        iss_valid = 0;
        lu_valid = 1; lu_waddr = 5'd9; lu_wdata = 32'h0000_0099;
        tick();
        lu_valid = 0;
        iss_valid = 1; iss_waddr = 5'd9;
        settle();
        chk("waw_pop_stall", 32'(stall_req), 32'd0);
        chk("waw_pop_waddr", 32'(rf_waddr), 32'd9);
        tick();
        iss_valid = 0;
        chk("waw_set_wins", pending, 32'h0000_0200);
        lu_valid = 1;
        tick();
        lu_valid = 0;
        tick();
        chk("waw_pending_clr", pending, 32'd0);

        // r0 result is accepted but never enqueued.
        wb_we = 1; wb_waddr = 5'd3; wb_wdata = 32'h3333_3333;
        lu_valid = 1; lu_waddr = 5'd20; lu_wdata = 32'h0000_0020;
        tick();
        lu_waddr = 5'd0; lu_wdata = 32'h0BAD_0BAD;
        settle();
        chk("r0_ready", 32'(lu_ready), 32'd1);
        tick();
        chk("r0_count_unchanged", 32'(lu_ready), 32'd1);
        lu_waddr = 5'd21; lu_wdata = 32'h0000_0021;
        tick();
        lu_valid = 0;
        chk("r0_then_full", 32'(lu_ready), 32'd0);
        wb_we = 0;
        settle();
        chk("r0_drain0", 32'(rf_waddr), 32'd20);
        tick();
        chk("r0_drain1", 32'(rf_waddr), 32'd21);
        chk("r0_drain1_data", rf_wdata, 32'h0000_0021);
        tick();
        chk("r0_never_written", 32'(rf_we), 32'd0);
        chk("final_pending", pending, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
